as_fetch_pf: RTL and testbench

Parametrised prefetching fetch stage for the RV64I pipeline. It replaces the single-PC fetch with a decoupled front end. It issues sequential requests to a 1-cycle-latency instruction memory and buffers the returned {pc, pc+4, instr} triples in a DEPTH-entry FIFO. It hands them to decode over a valid/ready handshake. Branch/jalr redirects from execute flush the buffer and drop any in-flight fetch.

---
 rtl/as_pack.sv | 16 +
 rtl/as_adder.sv | 14 +
 rtl/as_sync_fifo.sv | 63 ++++++
 rtl/as_fetch_pf.sv | 125 ++++++++++++
 tb/tb_as_fetch_pf.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/as_pack.sv
// Shared pipeline constants and types for the RV64I front end.
//   iaddr_width   : PC / instruction-memory address width
//   INSTR_W       : instruction word width
//   fetch_entry_t : one buffered fetch result {pc, pc+4, instr}
package as_pack;

    localparam int unsigned iaddr_width = 64;
    localparam int unsigned INSTR_W     = 32;

    typedef struct packed {
        logic [iaddr_width-1:0] pc;
        logic [iaddr_width-1:0] pc_4;
        logic [INSTR_W-1:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/as_adder.sv
// Plain modulo-2^WIDTH adder used for PC arithmetic.
//   a_i, b_i : operands
//   sum_o    : a_i + b_i, carry out discarded
module as_adder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/as_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count.
//   clk_i       : clock
//   flush_i     : synchronous clear of pointers and count (storage kept)
//   push_i      : write push_data_i (accepted when not full, or when popping)
//   push_data_i : entry to write
//   pop_i       : advance head (ignored when empty)
//   head_o      : current head entry, stale when empty
//   count_o     : occupancy 0..DEPTH
//   empty_o     : no valid entries
module as_sync_fifo #(
    parameter type         entry_t = logic [7:0],
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & !empty_o;
    // A pop frees the slot in the same cycle, so push at full is fine then.
    assign do_push = push_i & (!full | do_pop);

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= push_data_i;
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/as_fetch_pf.sv
// Prefetching fetch stage: issues sequential requests to a 1-cycle-latency
// instruction memory, buffers {pc, pc+4, instr} in a DEPTH-entry FIFO and
// hands them to decode over valid/ready. Redirects flush everything.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   redirect_i/_pc_i     : taken branch / jalr and its target
//   imem_req_o/_addr_o   : memory request and address (fetch PC)
//   imem_rdata_i         : data for last cycle's request
//   out_valid_o/ready_i  : decode handshake
//   out_pc_o/_pc_4_o     : head PC and return address
//   out_instr_o          : head instruction
//   count_o              : FIFO occupancy
module as_fetch_pf #(
    parameter int unsigned         IADDR_W  = as_pack::iaddr_width,
    parameter int unsigned         INSTR_W  = as_pack::INSTR_W,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [IADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     redirect_i,
    input  logic [IADDR_W-1:0]       redirect_pc_i,
    output logic                     imem_req_o,
    output logic [IADDR_W-1:0]       imem_addr_o,
    input  logic [INSTR_W-1:0]       imem_rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [IADDR_W-1:0]       out_pc_o,
    output logic [IADDR_W-1:0]       out_pc_4_o,
    output logic [INSTR_W-1:0]       out_instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    import as_pack::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [IADDR_W-1:0] fetch_pc;
    logic [IADDR_W-1:0] fetch_pc_4;
    logic [IADDR_W-1:0] req_pc;
    logic [IADDR_W-1:0] req_pc_4;
    logic               inflight;
    logic               flush;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CW-1:0]      count;
    logic [OW-1:0]      occ;
    logic               fifo_empty;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    // Reset acts as a redirect to RESET_PC for as long as it is held.
    assign flush = rst_i | redirect_i;
    assign pop   = out_valid_o & out_ready_i;

    // Slots committed = buffered + in flight, minus what decode takes now.
    // The ready->req combinational path lets DEPTH=2 sustain full rate.
    always_comb begin
        occ = OW'(count) + OW'(inflight) - OW'(pop);
    end

    assign issue       = !flush & (occ < OW'(DEPTH));
    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc;

    as_adder #(.WIDTH(IADDR_W)) u_fetch_inc (
        .a_i   (fetch_pc),
        .b_i   (IADDR_W'(4)),
        .sum_o (fetch_pc_4)
    );

    as_adder #(.WIDTH(IADDR_W)) u_ret_inc (
        .a_i   (req_pc),
        .b_i   (IADDR_W'(4)),
        .sum_o (req_pc_4)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc_4;
            end
        end
    end

    // The response landing in a flush cycle belongs to the dead stream.
    assign push = inflight & !flush;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = req_pc;
        push_entry.pc_4  = req_pc_4;
        push_entry.instr = imem_rdata_i;
    end

    as_sync_fifo #(
        .entry_t (fetch_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;
    assign out_pc_o    = head.pc;
    assign out_pc_4_o  = head.pc_4;
    assign out_instr_o = head.instr;
    assign count_o     = count;

endmodule

// File: tb/tb_as_fetch_pf.sv
module tb_as_fetch_pf;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_pc_4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    as_fetch_pf #(
        .IADDR_W  (64),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_pc_o      (out_pc),
        .out_pc_4_o    (out_pc_4),
        .out_instr_o   (out_instr),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h13;
    endfunction

    // Instruction memory: answers the address seen at the edge one cycle later.
    always @(posedge clk) imem_rdata <= instr_of(imem_addr);

    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] issue_exp = '0;
    int          since = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: after any flush to target T, decode must see T, T+4, T+8...
    // in order; nothing for two cycles after the flush, then valid forever
    // until the next flush; requests walk the same sequence.
    always @(negedge clk) begin
        int          s;
        logic [63:0] e;
        logic [63:0] tgt;
        if (mon_en) begin
            s = since + 1;
            if (rst || redirect) chk("req_during_flush", 64'(imem_req), 64'd0);
            if (s == 1) begin
                chk("count_after_flush", 64'(count), 64'd0);
                chk("valid_after_flush", 64'(out_valid), 64'd0);
            end else if (s == 2) begin
                chk("valid_r2", 64'(out_valid), 64'd0);
            end else begin
                chk("valid_steady", 64'(out_valid), 64'd1);
            end
            chk("count_range", 64'(count <= 3'(DEPTH)), 64'd1);
            if (imem_req) begin
                chk("issue_addr", imem_addr, issue_exp);
                issue_exp = issue_exp + 64'd4;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_unexpected: got pc %h expected none", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e);
                    chk("out_pc_4", out_pc_4, e + 64'd4);
                    chk("out_instr", 64'(out_instr), 64'(instr_of(e)));
                end
            end
            if (rst || redirect) begin
                tgt = rst ? RESET_PC : redirect_pc;
                exp_q.delete();
                for (int i = 0; i < 8; i++) exp_q.push_back(tgt + 64'(4 * i));
                issue_exp = tgt;
                since = 0;
            end else begin
                since = s;
                while (exp_q.size() > 0 && exp_q.size() < 8)
                    exp_q.push_back(exp_q[$] + 64'd4);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int mode;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);

        // Stall from reset: FIFO fills, requests stop at 0xC, then resume.
        rst = 1'b1;
        out_ready = 1'b0;
        step(1);
        rst = 1'b0;
        step(12);
        #1;
        chk("stall_count", 64'(count), 64'(DEPTH));
        chk("stall_req", 64'(imem_req), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("release_req", 64'(imem_req), 64'd1);
        chk("release_addr", imem_addr, RESET_PC + 64'h10);
        step(8);

        // Redirect with entries buffered and a request in flight.
        out_ready = 1'b0;
        step(3);
        redirect    = 1'b1;
        redirect_pc = 64'h1000;
        step(1);
        redirect  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("r1_count", 64'(count), 64'd0);
        chk("r1_valid", 64'(out_valid), 64'd0);
        chk("r1_addr", imem_addr, 64'h1000);
        chk("r1_req", 64'(imem_req), 64'd1);
        step(10);

        // Address wrap at the top of the space.
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1);
        redirect = 1'b0;
        step(8);

        // Back-to-back redirects, last wins.
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        step(1);
        redirect_pc = 64'h3000;
        step(1);
        redirect = 1'b0;
        step(6);

        // Reset pulse with a full FIFO.
        out_ready = 1'b0;
        step(12);
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        out_ready = 1'b1;
        step(10);

        // Randomized traffic.
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = ($urandom_range(0, 5) == 0);
            endcase
            rst      = ($urandom_range(0, 299) == 0);
            redirect = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
            else
                redirect_pc = {$urandom, $urandom} & ~64'h3;
            step(1);
        end
        rst       = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b1;
        step(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
